mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Params: DW=64, data/address width; DMEM_TIMEOUT none, no timeout, memory SHALL always ack.
REQ-002 clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 M_stat, M_icode, M_ifun, M_destE, M_destM  in  4 each  memory-stage pipeline register contents.
REQ-004 M_cnd  in  1; M_valA, M_valE  in  64  memory-stage operands.
REQ-005 W_stall  in  1  hold W register (writeback exception stall).
REQ-006 dmem_req  out 1; dmem_we  out 1; dmem_addr  out 64; dmem_wdata  out 64  data-memory request.
REQ-007 dmem_ack  in  1; dmem_rdata  in  64; dmem_err  in  1  data-memory response, valid only with ack.
REQ-008 m_stall  out 1  request upstream hold of M register and earlier stages.
REQ-009 m_stat  out 4; m_valM  out 64  memory-stage result for forwarding/control.
REQ-010 W_stat, W_icode, W_destE, W_destM  out 4; W_valE, W_valM  out 64  writeback register.

Function
REQ-011 Read ops: MRMOVQ(5), POPQ(B), RET(9); write ops: RMMOVQ(4), PUSHQ(A), CALL(8); all others non-memory.
REQ-012 Address: valA for POPQ/RET, valE otherwise; write data always M_valA.
REQ-013 Memory access SHALL occur only when M_stat==AOK(1) and M_icode is a memory op; otherwise no request, m_stat=M_stat, m_valM=0.
REQ-014 FSM states IDLE, BUSY, DONE; reset to IDLE.
REQ-015 IDLE: memory op present -> latch addr/we/wdata, go BUSY; else stay.
REQ-016 BUSY: dmem_req=1 with addr/we/wdata stable; on dmem_ack latch rdata (reads) and err, go DONE; without ack stay BUSY indefinitely.
REQ-017 DONE: m_valM=latched rdata (0 for writes), m_stat=ADR(3) if latched err else AOK; stays DONE while W_stall=1, else IDLE.
REQ-018 m_stall=1 when memory op present and state!=DONE, or W_stall=1; combinational.
REQ-019 W register SHALL load {m_stat, M_icode, M_destE, M_destM, M_valE, m_valM} on a rising edge where m_stall=0; otherwise hold.
REQ-020 Minimum memory-op latency: IDLE, BUSY (ack same cycle), DONE = 3 cycles M-to-W; non-memory ops 1 cycle.
REQ-021 dmem_ack outside BUSY SHALL be ignored; ack with err: err wins, m_valM=0.
REQ-022 Back-to-back memory ops: DONE->IDLE->BUSY, no request in the IDLE cycle.
REQ-023 dmem_req SHALL be registered (state-decoded), never combinational from dmem_ack.

Reset
REQ-024 rst_n low asynchronously: state=IDLE, dmem_req=0, dmem_we=0, addr/wdata=0, latched rdata/err=0.
REQ-025 Reset values: W_icode=NOP(1), W_stat=AOK(1), W_destE=W_destM=F, W_valE=W_valM=0.
REQ-026 Reset mid-BUSY SHALL drop dmem_req in the same cycle; late ack after release ignored.

Structure
REQ-027 Shared package y86_pkg: icode constants (HALT..POPQ), stat codes AOK/HLT/ADR/INS, RNONE=F.
REQ-028 FSM state enum local to mem_stage.
REQ-029 One sub-module w_reg: W pipeline register with load enable and async active-low reset.

Verification
REQ-030 IRMOVQ (3), valE=0x2A, destE=2 -> W_valE=0x2A, W_destE=2 next edge, dmem_req never high.
REQ-031 MRMOVQ valE=0x100, ack in 1st BUSY cycle rdata=0xDEAD -> addr=0x100, we=0, m_stall high 2 cycles, W_valM=0xDEAD after 3rd edge.
REQ-032 PUSHQ valE=0x1F8 valA=0x55, ack after 4 BUSY cycles -> we=1, wdata=0x55, addr stable throughout, W_valM=0.
REQ-033 POPQ valA=0x200, ack+err -> m_stat=ADR, W_stat=3, W_valM=0.
REQ-034 Reset asserted in BUSY -> dmem_req 0 immediately, W_icode=1, W_destE=F; stray ack after release ignored.
REQ-035 W_stall=1 during DONE for 3 cycles -> W holds, m_stall=1, state DONE, then loads on release.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and memory-op classification.
package y86_pkg;
    localparam int DW = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    localparam logic [3:0] RNONE = 4'hF;

    function automatic logic is_mem_read(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
    endfunction

    function automatic logic is_mem_write(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
    endfunction
endpackage

// File: rtl/w_reg.sv
// Writeback pipeline register; loads when enabled, resets to a bubble (NOP, AOK, no destinations).
module w_reg
    import y86_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [3:0]    d_stat,
    input  logic [3:0]    d_icode,
    input  logic [3:0]    d_destE,
    input  logic [3:0]    d_destM,
    input  logic [DW-1:0] d_valE,
    input  logic [DW-1:0] d_valM,
    output logic [3:0]    W_stat,
    output logic [3:0]    W_icode,
    output logic [3:0]    W_destE,
    output logic [3:0]    W_destM,
    output logic [DW-1:0] W_valE,
    output logic [DW-1:0] W_valM
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            W_stat  <= S_AOK;
            W_icode <= I_NOP;
            W_destE <= RNONE;
            W_destM <= RNONE;
            W_valE  <= '0;
            W_valM  <= '0;
        end else if (load) begin
            W_stat  <= d_stat;
            W_icode <= d_icode;
            W_destE <= d_destE;
            W_destM <= d_destM;
            W_valE  <= d_valE;
            W_valM  <= d_valM;
        end
    end
endmodule

// File: rtl/mem_stage.sv
// Memory stage: sequences one data-memory transaction per memory op and feeds the W register.
// state | meaning
// IDLE  | no transaction; a memory op in M latches the request
// BUSY  | dmem_req held with stable addr/we/wdata until ack
// DONE  | response latched and presented on m_stat/m_valM until W accepts it
module mem_stage
    import y86_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    M_stat,
    input  logic [3:0]    M_icode,
    input  logic [3:0]    M_ifun,
    input  logic [3:0]    M_destE,
    input  logic [3:0]    M_destM,
    input  logic          M_cnd,
    input  logic [DW-1:0] M_valA,
    input  logic [DW-1:0] M_valE,
    input  logic          W_stall,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_err,
    output logic          m_stall,
    output logic [3:0]    m_stat,
    output logic [DW-1:0] m_valM,
    output logic [3:0]    W_stat,
    output logic [3:0]    W_icode,
    output logic [3:0]    W_destE,
    output logic [3:0]    W_destM,
    output logic [DW-1:0] W_valE,
    output logic [DW-1:0] W_valM
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t        state, state_nxt;
    logic          mem_op, latch_req, latch_rsp;
    logic          we_q, err_q;
    logic [DW-1:0] addr_q, wdata_q, rdata_q;
    logic          unused_inputs;

    // Function code and condition flag have no role in the memory stage.
    assign unused_inputs = ^{M_ifun, M_cnd};

    assign mem_op = (M_stat == S_AOK) && (is_mem_read(M_icode) || is_mem_write(M_icode));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch_req = 1'b0;
        latch_rsp = 1'b0;
        case (state)
            ST_IDLE: if (mem_op) begin
                latch_req = 1'b1;
                state_nxt = ST_BUSY;
            end
            ST_BUSY: if (dmem_ack) begin
                latch_rsp = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: if (!W_stall) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (latch_req) begin
                addr_q  <= (M_icode == I_POPQ || M_icode == I_RET) ? M_valA : M_valE;
                wdata_q <= M_valA;
                we_q    <= is_mem_write(M_icode);
            end
            // An error response discards read data so a faulting load forwards zero.
            if (latch_rsp) begin
                rdata_q <= (we_q || dmem_err) ? '0 : dmem_rdata;
                err_q   <= dmem_err;
            end
        end
    end

    assign dmem_req   = (state == ST_BUSY);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

    assign m_stall = (mem_op && state != ST_DONE) || W_stall;
    assign m_stat  = (state == ST_DONE) ? (err_q ? S_ADR : S_AOK) : M_stat;
    assign m_valM  = (state == ST_DONE) ? rdata_q : '0;

    w_reg #(.DW(DW)) u_w_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (!m_stall),
        .d_stat  (m_stat),
        .d_icode (M_icode),
        .d_destE (M_destE),
        .d_destM (M_destM),
        .d_valE  (M_valE),
        .d_valM  (m_valM),
        .W_stat  (W_stat),
        .W_icode (W_icode),
        .W_destE (W_destE),
        .W_destM (W_destM),
        .W_valE  (W_valE),
        .W_valM  (W_valM)
    );
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus W-register scoreboard and reset corner case.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  M_stat, M_icode, M_ifun, M_destE, M_destM;
    logic        M_cnd;
    logic [63:0] M_valA, M_valE;
    logic        W_stall;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic        dmem_ack, dmem_err;
    logic [63:0] dmem_rdata;
    logic        m_stall;
    logic [3:0]  m_stat;
    logic [63:0] m_valM;
    logic [3:0]  W_stat, W_icode, W_destE, W_destM;
    logic [63:0] W_valE, W_valM;

    mem_stage #(.DW(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .M_stat(M_stat), .M_icode(M_icode), .M_ifun(M_ifun), .M_destE(M_destE), .M_destM(M_destM),
        .M_cnd(M_cnd), .M_valA(M_valA), .M_valE(M_valE), .W_stall(W_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
        .m_stall(m_stall), .m_stat(m_stat), .m_valM(m_valM),
        .W_stat(W_stat), .W_icode(W_icode), .W_destE(W_destE), .W_destM(W_destM),
        .W_valE(W_valE), .W_valM(W_valM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  stat, icode, destE, destM;
        logic [63:0] valA, valE, rdata;
        int          delay;
        logic        err;
        int          wstall;
        logic        stray;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_stat;
        logic [63:0] exp_valM;
        int          exp_stalls;
    } vec_t;

    typedef struct {
        logic [3:0]  stat, icode, destE, destM;
        logic [63:0] valE, valM;
    } w_exp_t;

    w_exp_t      sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] last_valE = 64'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] stat, input logic [3:0] icode,
                                input logic [3:0] destE, input logic [3:0] destM,
                                input logic [63:0] valA, input logic [63:0] valE,
                                input logic [63:0] rdata, input int delay, input logic err,
                                input int wstall, input logic stray, input logic exp_req,
                                input logic [63:0] exp_addr, input logic exp_we,
                                input logic [3:0] exp_stat, input logic [63:0] exp_valM,
                                input int exp_stalls);
        vec_t v;
        v.stat = stat; v.icode = icode; v.destE = destE; v.destM = destM;
        v.valA = valA; v.valE = valE; v.rdata = rdata; v.delay = delay; v.err = err;
        v.wstall = wstall; v.stray = stray; v.exp_req = exp_req; v.exp_addr = exp_addr;
        v.exp_we = exp_we; v.exp_stat = exp_stat; v.exp_valM = exp_valM; v.exp_stalls = exp_stalls;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        w_exp_t e, got;
        int busy = 0, stalls = 0, ws_left = v.wstall;
        bit in_done = 0, ack_prev = 0, req_seen = 0, done_ok = 0;
        M_stat = v.stat; M_icode = v.icode; M_ifun = 4'h0; M_destE = v.destE; M_destM = v.destM;
        M_cnd = 1'b0; M_valA = v.valA; M_valE = v.valE;
        W_stall = 1'b0; dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = v.rdata;
        e.stat = v.exp_stat; e.icode = v.icode; e.destE = v.destE; e.destM = v.destM;
        e.valE = v.valE; e.valM = v.exp_valM;
        sb.push_back(e);
        for (int cyc = 0; cyc < 60 && !done_ok; cyc++) begin
            @(negedge clk);
            if (ack_prev) in_done = 1;
            W_stall = in_done && (ws_left > 0);
            if (W_stall) ws_left--;
            dmem_ack = 1'b0; dmem_err = 1'b0;
            #1;
            if (dmem_req) begin
                req_seen = 1; busy++;
                if (busy == 1) chk($sformatf("v%0d_first_req_cycle_nonzero", idx), (cyc == 0), 0);
                chk($sformatf("v%0d_addr", idx), dmem_addr, v.exp_addr);
                chk($sformatf("v%0d_we", idx), dmem_we, v.exp_we);
                chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.valA);
                if (busy == v.delay + 1) begin
                    dmem_ack = 1'b1;
                    dmem_err = v.err;
                end
            end else begin
                dmem_ack = v.stray;
            end
            ack_prev = dmem_req && dmem_ack;
            if (m_stall) begin
                stalls++;
                if (in_done) begin
                    chk($sformatf("v%0d_m_stat_done", idx), m_stat, v.exp_stat);
                    chk($sformatf("v%0d_m_valM_done", idx), m_valM, v.exp_valM);
                end
                if (W_stall) chk($sformatf("v%0d_W_hold", idx), W_valE, last_valE);
            end else begin
                chk($sformatf("v%0d_m_stat", idx), m_stat, v.exp_stat);
                chk($sformatf("v%0d_m_valM", idx), m_valM, v.exp_valM);
                done_ok = 1;
            end
        end
        if (!done_ok) begin
            n_checks++; n_fail++;
            $display("FAIL v%0d_timeout: m_stall never released within 60 cycles", idx);
            void'(sb.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk($sformatf("v%0d_W_stat", idx), W_stat, got.stat);
        chk($sformatf("v%0d_W_icode", idx), W_icode, got.icode);
        chk($sformatf("v%0d_W_destE", idx), W_destE, got.destE);
        chk($sformatf("v%0d_W_destM", idx), W_destM, got.destM);
        chk($sformatf("v%0d_W_valE", idx), W_valE, got.valE);
        chk($sformatf("v%0d_W_valM", idx), W_valM, got.valM);
        chk($sformatf("v%0d_stall_cycles", idx), stalls, v.exp_stalls);
        chk($sformatf("v%0d_req_seen", idx), req_seen, v.exp_req);
        last_valE = got.valE;
    endtask

    vec_t vecs[11];
    bit   got_req;

    initial begin
        //                stat  icode destE destM valA          valE          rdata         dly err ws stray req addr          we   stat  valM          stalls
        vecs[0]  = mk(4'h1, 4'h3, 4'h2, 4'hF, 64'h0,        64'h2A,       64'h0,        0, 0, 0, 0, 0, 64'h0,        0, 4'h1, 64'h0,        0);
        vecs[1]  = mk(4'h1, 4'h5, 4'hF, 4'h3, 64'h7,        64'h100,      64'hDEAD,     0, 0, 0, 0, 1, 64'h100,      0, 4'h1, 64'hDEAD,     2);
        vecs[2]  = mk(4'h1, 4'hA, 4'h4, 4'hF, 64'h55,       64'h1F8,      64'hFFFF,     4, 0, 0, 0, 1, 64'h1F8,      1, 4'h1, 64'h0,        6);
        vecs[3]  = mk(4'h1, 4'hB, 4'h4, 4'h5, 64'h200,      64'h208,      64'h1234,     0, 1, 0, 0, 1, 64'h200,      0, 4'h3, 64'h0,        2);
        vecs[4]  = mk(4'h1, 4'h9, 4'h4, 4'hF, 64'h300,      64'h308,      64'h400,      1, 0, 0, 0, 1, 64'h300,      0, 4'h1, 64'h400,      3);
        vecs[5]  = mk(4'h1, 4'h5, 4'hF, 4'h6, 64'h1,        64'h80,       64'hBEEF,     0, 0, 3, 0, 1, 64'h80,       0, 4'h1, 64'hBEEF,     5);
        vecs[6]  = mk(4'h1, 4'h4, 4'hF, 4'hF, 64'h99,       64'h40,       64'h7777,     0, 0, 0, 0, 1, 64'h40,       1, 4'h1, 64'h0,        2);
        vecs[7]  = mk(4'h1, 4'h8, 4'h4, 4'hF, 64'h13,       64'h1F0,      64'h0,        2, 0, 0, 0, 1, 64'h1F0,      1, 4'h1, 64'h0,        4);
        vecs[8]  = mk(4'h2, 4'h5, 4'hF, 4'h3, 64'h0,        64'h100,      64'hDEAD,     0, 0, 0, 0, 0, 64'h0,        0, 4'h2, 64'h0,        0);
        vecs[9]  = mk(4'h1, 4'h6, 4'h7, 4'hF, 64'h5,        64'hCAFE,     64'h9999,     0, 0, 0, 1, 0, 64'h0,        0, 4'h1, 64'h0,        0);
        vecs[10] = mk(4'h1, 4'h1, 4'hF, 4'hF, 64'h0,        64'h0,        64'h0,        0, 0, 0, 0, 0, 64'h0,        0, 4'h1, 64'h0,        0);

        rst_n = 1'b0;
        M_stat = 4'h1; M_icode = 4'h1; M_ifun = 4'h0; M_destE = 4'hF; M_destM = 4'hF;
        M_cnd = 1'b0; M_valA = '0; M_valE = '0; W_stall = 1'b0;
        dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_W_icode", W_icode, 4'h1);
        chk("rst_W_stat", W_stat, 4'h1);
        chk("rst_W_destE", W_destE, 4'hF);
        chk("rst_W_destM", W_destM, 4'hF);
        chk("rst_W_valE", W_valE, 64'h0);
        chk("rst_W_valM", W_valM, 64'h0);
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_dmem_addr", dmem_addr, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Reset while BUSY must drop the request at once; a late ack afterwards is ignored.
        M_stat = 4'h1; M_icode = 4'h5; M_destE = 4'hF; M_destM = 4'h2;
        M_valA = 64'h0; M_valE = 64'h500; W_stall = 1'b0; dmem_ack = 1'b0;
        got_req = 0;
        for (int c = 0; c < 5 && !got_req; c++) begin
            @(negedge clk);
            #1;
            got_req = dmem_req;
        end
        chk("rstb_req_reached_busy", got_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstb_req_dropped", dmem_req, 1'b0);
        chk("rstb_W_icode", W_icode, 4'h1);
        chk("rstb_W_destE", W_destE, 4'hF);
        chk("rstb_W_stat", W_stat, 4'h1);
        M_icode = 4'h1; M_destM = 4'hF; M_valE = 64'h0;
        dmem_ack = 1'b1; dmem_rdata = 64'hBAD; dmem_err = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("rstb_stray_ack_no_req", dmem_req, 1'b0);
            chk("rstb_stray_ack_no_stall", m_stall, 1'b0);
            chk("rstb_stray_ack_m_stat", m_stat, 4'h1);
        end
        @(posedge clk);
        #1;
        chk("rstb_W_icode_after", W_icode, 4'h1);
        chk("rstb_W_valM_after", W_valM, 64'h0);
        chk("rstb_W_stat_after", W_stat, 4'h1);
        dmem_ack = 1'b0; dmem_err = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
